// File: rtl/axi_lite_ram_if.sv
// ---------------------------------------------------------------------------
// axi_lite_ram_if
//
// AXI4-Lite bus bundle used between the core's AXI4-Lite master port and
// axi_lite_ram. All addresses are byte addresses and data is 32 bits wide.
//
// Signals:
//   AWdata/AWvalid/AWready/AWprot  write address channel (prot is ignored)
//   Wdata/Wstrb/Wvalid/Wready      write data channel, Wstrb[n] -> byte n
//   Bvalid/Bready/Bresp            write response channel
//   ARdata/ARvalid/ARready/ARprot  read address channel (prot is ignored)
//   Rdata/Rvalid/Rready/Rresp      read data channel
//
// Modports: master (drives requests) and slave (the memory).
// ---------------------------------------------------------------------------
interface axi_lite_ram_if;
    logic [31:0] AWdata;
    logic        AWvalid;
    logic        AWready;
    logic [2:0]  AWprot;
    logic [31:0] Wdata;
    logic [3:0]  Wstrb;
    logic        Wvalid;
    logic        Wready;
    logic        Bvalid;
    logic        Bready;
    logic [1:0]  Bresp;
    logic [31:0] ARdata;
    logic        ARvalid;
    logic        ARready;
    logic [2:0]  ARprot;
    logic [31:0] Rdata;
    logic        Rvalid;
    logic        Rready;
    logic [1:0]  Rresp;

    modport master (
        output AWdata, AWvalid, AWprot, Wdata, Wstrb, Wvalid, Bready,
               ARdata, ARvalid, ARprot, Rready,
        input  AWready, Wready, Bvalid, Bresp, ARready, Rdata, Rvalid, Rresp
    );

    modport slave (
        input  AWdata, AWvalid, AWprot, Wdata, Wstrb, Wvalid, Bready,
               ARdata, ARvalid, ARprot, Rready,
        output AWready, Wready, Bvalid, Bresp, ARready, Rdata, Rvalid, Rresp
    );
endinterface

// File: rtl/axi_lite_ram.sv
// ---------------------------------------------------------------------------
// axi_lite_ram
//
// AXI4-Lite slave word memory (2**ADDR_WIDTH x 32 bits) with byte-lane write
// strobes, independent read and write channel FSMs and a parameterised read
// latency.
//
// Parameters:
//   ADDR_WIDTH  word-index bits, depth = 2**ADDR_WIDTH words
//   BASE_ADDR   byte address of word 0 (4-byte aligned)
//   READ_LAT    extra wait cycles before Rvalid, 0..7
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset
//   bus   axi_lite_ram_if.slave (AW/W/B/AR/R channels)
//
// Optional feature: define AXIRAM_RANGE_CHECK_EN to reject accesses outside
// [BASE_ADDR, BASE_ADDR + 4*2**ADDR_WIDTH) with SLVERR. Without it the
// address is simply truncated, so the array aliases across the address map.
// ---------------------------------------------------------------------------
module axi_lite_ram #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned READ_LAT   = 0
) (
    input  logic          clk,
    input  logic          rst,
    axi_lite_ram_if.slave bus
);

    localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [2:0]  LAT       = 3'(READ_LAT);
    localparam logic [1:0]  RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP}   r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    // -----------------------------------------------------------------------
    // Address decode
    // -----------------------------------------------------------------------
    logic [31:0]           aw_off, ar_off;
    logic [ADDR_WIDTH-1:0] aw_idx_in, ar_idx_in;
    logic                  aw_in_range, ar_in_range;

    assign aw_off    = bus.AWdata - BASE_ADDR;
    assign ar_off    = bus.ARdata - BASE_ADDR;
    assign aw_idx_in = aw_off[ADDR_WIDTH+1:2];
    assign ar_idx_in = ar_off[ADDR_WIDTH+1:2];

`ifdef AXIRAM_RANGE_CHECK_EN
    localparam logic [32:0] SPAN        = 33'(DEPTH) << 2;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    // The 33-bit compare keeps the span exact even when it reaches 2**32.
    assign aw_in_range = (bus.AWdata >= BASE_ADDR) && ({1'b0, aw_off} < SPAN);
    assign ar_in_range = (bus.ARdata >= BASE_ADDR) && ({1'b0, ar_off} < SPAN);
`else
    assign aw_in_range = 1'b1;
    assign ar_in_range = 1'b1;
`endif

    // Protection bits, byte-offset bits and out-of-index offset bits carry
    // no meaning for this memory.
    logic unused;
    assign unused = &{1'b0, bus.AWprot, bus.ARprot, aw_off, ar_off};

    // -----------------------------------------------------------------------
    // Handshakes
    // -----------------------------------------------------------------------
    logic aw_hs, w_hs, ar_hs;

    assign aw_hs = bus.AWvalid && bus.AWready;
    assign w_hs  = bus.Wvalid  && bus.Wready;
    assign ar_hs = bus.ARvalid && bus.ARready;

    // -----------------------------------------------------------------------
    // Storage
    // -----------------------------------------------------------------------
    logic [31:0] mem [DEPTH];

    // Write-side held request
    logic                  aw_held, w_held;
    logic [ADDR_WIDTH-1:0] aw_idx;
    logic                  aw_ok;
    logic [31:0]           w_data;
    logic [3:0]            w_strb;

    // Read-side held request and response register
    logic [ADDR_WIDTH-1:0] r_idx;
    logic                  r_ok;
    logic [2:0]            r_cnt;
    logic [31:0]           rdata_q;

    // Read capture controls, decided by the read next-state logic
    logic                  r_capture;
    logic [ADDR_WIDTH-1:0] cap_idx;
    logic                  cap_ok;

    // NOTE: the array is deliberately left out of reset so it maps onto RAM
    // macros; a write sitting in W_COMMIT on a reset edge is dropped by
    // qualifying the enable with ~rst.
    always_ff @(posedge clk) begin
        if (!rst && (w_state == W_COMMIT) && aw_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (w_strb[b]) begin
                    mem[aw_idx][8*b +: 8] <= w_data[8*b +: 8];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Write FSM: state register / next state / outputs
    // -----------------------------------------------------------------------
    // NOTE: every sequential block uses non-blocking assignments so all
    // registers update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_next;
        end
    end

    // NOTE: each combinational block assigns defaults first so no path can
    // leave an output unassigned and infer a latch.
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE: begin
                // Address and data may arrive in either order or together.
                if ((aw_held || aw_hs) && (w_held || w_hs)) begin
                    w_next = W_COMMIT;
                end
            end
            W_COMMIT: w_next = W_RESP;
            W_RESP: begin
                if (bus.Bready) begin
                    w_next = W_IDLE;
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        bus.AWready = 1'b0;
        bus.Wready  = 1'b0;
        bus.Bvalid  = 1'b0;
        bus.Bresp   = RESP_OKAY;
        if (!rst) begin
            bus.AWready = (w_state == W_IDLE) && !aw_held;
            bus.Wready  = (w_state == W_IDLE) && !w_held;
            bus.Bvalid  = (w_state == W_RESP);
`ifdef AXIRAM_RANGE_CHECK_EN
            if ((w_state == W_RESP) && !aw_ok) begin
                bus.Bresp = RESP_SLVERR;
            end
`endif
        end
    end

    // Held write request
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            aw_idx  <= '0;
            aw_ok   <= 1'b0;
            w_data  <= '0;
            w_strb  <= '0;
        end else begin
            if (aw_hs) begin
                aw_held <= 1'b1;
                aw_idx  <= aw_idx_in;
                aw_ok   <= aw_in_range;
            end
            if (w_hs) begin
                w_held <= 1'b1;
                w_data <= bus.Wdata;
                w_strb <= bus.Wstrb;
            end
            if ((w_state == W_RESP) && bus.Bready) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read FSM: state register / next state / outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_next;
        end
    end

    always_comb begin
        r_next    = r_state;
        r_capture = 1'b0;
        cap_idx   = r_idx;
        cap_ok    = r_ok;
        case (r_state)
            R_IDLE: begin
                if (ar_hs) begin
                    if (LAT == 3'd0) begin
                        // Zero latency: sample the array on the AR edge.
                        r_capture = 1'b1;
                        cap_idx   = ar_idx_in;
                        cap_ok    = ar_in_range;
                        r_next    = R_RESP;
                    end else begin
                        r_next = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (r_cnt == 3'd1) begin
                    r_capture = 1'b1;
                    r_next    = R_RESP;
                end
            end
            R_RESP: begin
                if (bus.Rready) begin
                    r_next = R_IDLE;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        bus.ARready = 1'b0;
        bus.Rvalid  = 1'b0;
        if (!rst) begin
            bus.ARready = (r_state == R_IDLE);
            bus.Rvalid  = (r_state == R_RESP);
        end
    end

    assign bus.Rdata = rdata_q;

    // Held read request and response data. The array is read with the
    // pre-edge contents, so a commit to the same word on the capture edge
    // is not yet visible and the read returns the old data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= '0;
            r_ok    <= 1'b0;
            r_cnt   <= '0;
            rdata_q <= '0;
        end else begin
            if (ar_hs) begin
                r_idx <= ar_idx_in;
                r_ok  <= ar_in_range;
                r_cnt <= LAT;
            end else if (r_state == R_WAIT) begin
                r_cnt <= r_cnt - 3'd1;
            end
            if (r_capture) begin
                rdata_q <= cap_ok ? mem[cap_idx] : 32'h0;
            end
        end
    end

`ifdef AXIRAM_RANGE_CHECK_EN
    logic [1:0] rresp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rresp_q <= RESP_OKAY;
        end else if (r_capture) begin
            rresp_q <= cap_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

    assign bus.Rresp = rresp_q;
`else
    assign bus.Rresp = RESP_OKAY;
`endif

endmodule

// File: tb/tb_axi_lite_ram.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_ram
//
// Directed bench for axi_lite_ram. Two instances share one stimulus set:
// dut0 has READ_LAT = 0 and dut1 has READ_LAT = 3; `sel` picks whose outputs
// are observed. Both use ADDR_WIDTH = 4 and BASE_ADDR = 32'h1000, so the
// first byte past the array is 32'h1040.
// ---------------------------------------------------------------------------
module tb_axi_lite_ram;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Shared stimulus
    logic [31:0] aw_addr, w_data, ar_addr;
    logic [3:0]  w_strb;
    logic        aw_valid, w_valid, b_ready, ar_valid, r_ready;
    logic        sel;
    int          cur_lat;

    int checks   = 0;
    int failures = 0;

    axi_lite_ram_if bus0 ();
    axi_lite_ram_if bus1 ();

    axi_lite_ram #(.ADDR_WIDTH(4), .BASE_ADDR(32'h0000_1000), .READ_LAT(0))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    axi_lite_ram #(.ADDR_WIDTH(4), .BASE_ADDR(32'h0000_1000), .READ_LAT(3))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    assign bus0.AWdata  = aw_addr;   assign bus1.AWdata  = aw_addr;
    assign bus0.AWvalid = aw_valid;  assign bus1.AWvalid = aw_valid;
    assign bus0.AWprot  = 3'b010;    assign bus1.AWprot  = 3'b010;
    assign bus0.Wdata   = w_data;    assign bus1.Wdata   = w_data;
    assign bus0.Wstrb   = w_strb;    assign bus1.Wstrb   = w_strb;
    assign bus0.Wvalid  = w_valid;   assign bus1.Wvalid  = w_valid;
    assign bus0.Bready  = b_ready;   assign bus1.Bready  = b_ready;
    assign bus0.ARdata  = ar_addr;   assign bus1.ARdata  = ar_addr;
    assign bus0.ARvalid = ar_valid;  assign bus1.ARvalid = ar_valid;
    assign bus0.ARprot  = 3'b001;    assign bus1.ARprot  = 3'b001;
    assign bus0.Rready  = r_ready;   assign bus1.Rready  = r_ready;

    logic        aw_ready, w_ready, b_valid, ar_ready, r_valid;
    logic [1:0]  b_resp, r_resp;
    logic [31:0] r_data;

    assign aw_ready = sel ? bus1.AWready : bus0.AWready;
    assign w_ready  = sel ? bus1.Wready  : bus0.Wready;
    assign b_valid  = sel ? bus1.Bvalid  : bus0.Bvalid;
    assign b_resp   = sel ? bus1.Bresp   : bus0.Bresp;
    assign ar_ready = sel ? bus1.ARready : bus0.ARready;
    assign r_valid  = sel ? bus1.Rvalid  : bus0.Rvalid;
    assign r_data   = sel ? bus1.Rdata   : bus0.Rdata;
    assign r_resp   = sel ? bus1.Rresp   : bus0.Rresp;

`ifdef AXIRAM_RANGE_CHECK_EN
    localparam logic [1:0]  OOR_RESP      = 2'b10;
    localparam logic [31:0] OOR_RDATA     = 32'h0000_0000;  // rejected read
    localparam logic [31:0] WORD1_AFTER   = 32'h0101_0101;  // rejected write
`else
    localparam logic [1:0]  OOR_RESP      = 2'b00;
    localparam logic [31:0] OOR_RDATA     = 32'h0000_00A5;  // aliases word 0
    localparam logic [31:0] WORD1_AFTER   = 32'hFFFF_EEEE;  // aliases word 1
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past n rising edges and settle 1 time unit after the last one.
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // AW and W together with Bready high; returns Bvalid/Bresp as seen two
    // cycles after the handshake edge.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic bv, output logic [1:0] br);
        aw_addr = a; w_data = d; w_strb = s;
        aw_valid = 1'b1; w_valid = 1'b1; b_ready = 1'b1;
        tick();
        aw_valid = 1'b0; w_valid = 1'b0;
        tick();
        bv = b_valid; br = b_resp;
        tick();
        b_ready = 1'b0;
    endtask

    // AR, then sample the R channel exactly cur_lat+1 cycles after the
    // handshake edge and accept it.
    task automatic do_read(input logic [31:0] a, output logic rv,
                           output logic [31:0] d, output logic [1:0] rr);
        ar_addr = a; ar_valid = 1'b1;
        tick();
        ar_valid = 1'b0;
        tick(cur_lat);
        rv = r_valid; d = r_data; rr = r_resp;
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
    endtask

    logic        bv, rv;
    logic [1:0]  br, rr;
    logic [31:0] rd;

    initial begin
        rst = 1'b1; sel = 1'b0; cur_lat = 0;
        aw_addr = '0; w_data = '0; w_strb = '0; ar_addr = '0;
        aw_valid = 1'b0; w_valid = 1'b0; b_ready = 1'b0; ar_valid = 1'b0; r_ready = 1'b0;

        // ---------------- reset state ----------------
        tick(2);
        chk("rst_readies", {29'd0, aw_ready, w_ready, ar_ready}, 32'd0);
        chk("rst_valids", {30'd0, b_valid, r_valid}, 32'd0);
        chk("rst_rdata", r_data, 32'd0);
        chk("rst_resps", {28'd0, b_resp, r_resp}, 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_readies", {29'd0, aw_ready, w_ready, ar_ready}, 32'd7);

        // ---------------- basic write then read, READ_LAT = 0 ----------------
        aw_addr = 32'h1010; w_data = 32'hCAFE_BABE; w_strb = 4'hF;
        aw_valid = 1'b1; w_valid = 1'b1; b_ready = 1'b1;
        tick();
        aw_valid = 1'b0; w_valid = 1'b0;
        chk("wr_commit_bvalid", {31'd0, b_valid}, 32'd0);
        chk("wr_commit_readies", {30'd0, aw_ready, w_ready}, 32'd0);
        tick();
        chk("wr_resp_bvalid", {31'd0, b_valid}, 32'd1);
        chk("wr_resp_bresp", {30'd0, b_resp}, 32'd0);
        tick();
        b_ready = 1'b0;
        chk("wr_done_bvalid", {31'd0, b_valid}, 32'd0);
        chk("wr_done_awready", {31'd0, aw_ready}, 32'd1);

        ar_addr = 32'h1010; ar_valid = 1'b1;
        tick();
        ar_valid = 1'b0;
        chk("rd0_rvalid", {31'd0, r_valid}, 32'd1);
        chk("rd0_rdata", r_data, 32'hCAFE_BABE);
        chk("rd0_arready_busy", {31'd0, ar_ready}, 32'd0);
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
        chk("rd0_done", {30'd0, r_valid, ar_ready}, 32'd1);

        // ---------------- byte strobes ----------------
        do_write(32'h1020, 32'h1122_3344, 4'hF, bv, br);
        do_write(32'h1020, 32'hAABB_CCDD, 4'b0101, bv, br);
        do_read(32'h1020, rv, rd, rr);
        chk("strb_rdata", rd, 32'h11BB_33DD);
        do_write(32'h1020, 32'hFFFF_FFFF, 4'h0, bv, br);
        chk("strb0_bvalid", {31'd0, bv}, 32'd1);
        do_read(32'h1020, rv, rd, rr);
        chk("strb0_rdata", rd, 32'h11BB_33DD);

        // ---------------- W before AW, B backpressure ----------------
        w_data = 32'h5A5A_0001; w_strb = 4'hF; w_valid = 1'b1;
        tick();
        w_valid = 1'b0;
        chk("w_first_readies", {30'd0, aw_ready, w_ready}, 32'd2);
        tick(2);
        aw_addr = 32'h1030; aw_valid = 1'b1;
        tick();
        aw_valid = 1'b0;
        chk("w_first_commit", {29'd0, aw_ready, w_ready, b_valid}, 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bp_hold_%0d", i), {29'd0, aw_ready, w_ready, b_valid}, 32'd1);
            tick();
        end
        b_ready = 1'b1;
        chk("bp_release_bvalid", {31'd0, b_valid}, 32'd1);
        tick();
        b_ready = 1'b0;
        chk("bp_idle", {29'd0, aw_ready, w_ready, b_valid}, 32'd6);
        do_read(32'h1030, rv, rd, rr);
        chk("bp_rdata", rd, 32'h5A5A_0001);

        // ---------------- same-word race ----------------
        aw_addr = 32'h1010; w_data = 32'h0BAD_F00D; w_strb = 4'hF;
        aw_valid = 1'b1; w_valid = 1'b1; b_ready = 1'b1;
        tick();
        aw_valid = 1'b0; w_valid = 1'b0;
        ar_addr = 32'h1010; ar_valid = 1'b1;   // AR edge == commit edge
        tick();
        ar_valid = 1'b0;
        chk("race_rdata_old", r_data, 32'hCAFE_BABE);
        chk("race_valids", {30'd0, r_valid, b_valid}, 32'd3);
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0; b_ready = 1'b0;
        do_read(32'h1010, rv, rd, rr);
        chk("race_rdata_new", rd, 32'h0BAD_F00D);

        // ---------------- READ_LAT = 3 ----------------
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        sel = 1'b1; cur_lat = 3;
        tick();
        do_write(32'h1008, 32'h1234_5678, 4'hF, bv, br);
        ar_addr = 32'h1008; ar_valid = 1'b1;
        chk("lat3_arready", {31'd0, ar_ready}, 32'd1);
        tick();
        ar_valid = 1'b0;
        chk("lat3_c1", {30'd0, r_valid, ar_ready}, 32'd0);
        tick();
        chk("lat3_c2", {31'd0, r_valid}, 32'd0);
        tick();
        chk("lat3_c3", {31'd0, r_valid}, 32'd0);
        tick();
        chk("lat3_c4_rvalid", {31'd0, r_valid}, 32'd1);
        chk("lat3_c4_rdata", r_data, 32'h1234_5678);
        tick();
        chk("lat3_c5_hold", {30'd0, r_valid, ar_ready}, 32'd2);
        chk("lat3_c5_rdata", r_data, 32'h1234_5678);
        tick();
        chk("lat3_c6_rdata", r_data, 32'h1234_5678);
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
        chk("lat3_done", {30'd0, r_valid, ar_ready}, 32'd1);

        // ---------------- range / aliasing ----------------
        do_write(32'h1000, 32'h0000_00A5, 4'hF, bv, br);
        chk("in_range_bresp", {30'd0, br}, 32'd0);
        do_write(32'h1004, 32'h0101_0101, 4'hF, bv, br);
        do_write(32'h1044, 32'hFFFF_EEEE, 4'hF, bv, br);
        chk("oor_bvalid", {31'd0, bv}, 32'd1);
        chk("oor_bresp", {30'd0, br}, {30'd0, OOR_RESP});
        do_read(32'h1040, rv, rd, rr);
        chk("oor_rvalid", {31'd0, rv}, 32'd1);
        chk("oor_rdata", rd, OOR_RDATA);
        chk("oor_rresp", {30'd0, rr}, {30'd0, OOR_RESP});
        do_read(32'h1004, rv, rd, rr);
        chk("word1_after_oor", rd, WORD1_AFTER);
        do_read(32'h1000, rv, rd, rr);
        chk("in_range_rresp", {30'd0, rr}, 32'd0);
        chk("in_range_rdata", rd, 32'h0000_00A5);

        // ---------------- reset during R_WAIT ----------------
        ar_addr = 32'h1008; ar_valid = 1'b1;
        tick();
        ar_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("rst_rwait_outputs", {30'd0, r_valid, ar_ready}, 32'd0);
        rst = 1'b0;
        tick();
        chk("rst_rwait_release", {30'd0, r_valid, ar_ready}, 32'd1);
        tick(4);
        chk("rst_rwait_abandoned", {31'd0, r_valid}, 32'd0);

        // ---------------- reset during W_COMMIT ----------------
        do_write(32'h100C, 32'h7777_7777, 4'hF, bv, br);
        aw_addr = 32'h100C; w_data = 32'h8888_8888; w_strb = 4'hF;
        aw_valid = 1'b1; w_valid = 1'b1;
        tick();
        aw_valid = 1'b0; w_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("rst_commit_idle", {30'd0, aw_ready, b_valid}, 32'd2);
        do_read(32'h100C, rv, rd, rr);
        chk("rst_commit_dropped", rd, 32'h7777_7777);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
